// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion and door controller for a 6-floor shaft.
// Follows the target floor from the destination computer, steps the car
// one floor every FLOOR_TICKS cycles, holds the door for DOOR_TICKS cycles
// and pulses request-clear strobes for the floor being served.
module elevator_motion_ctrl #(
    parameter int unsigned FLOOR_TICKS = 50,
    parameter int unsigned DOOR_TICKS  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] des,
    input  logic       des_valid,
    input  logic [5:0] req_in,
    input  logic [9:0] req_out,
    output logic [2:0] now,
    output logic       dir,
    output logic       moving,
    output logic       door_open,
    output logic       arrive,
    output logic [5:0] clr_in,
    output logic [9:0] clr_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    localparam logic [15:0] FLOOR_LAST = 16'(FLOOR_TICKS - 1);
    localparam logic [15:0] DOOR_LAST  = 16'(DOOR_TICKS - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  now_q;
    logic        dir_q;
    logic        moving_q;
    logic        door_q;
    logic        arrive_q;
    logic [5:0]  clr_in_q;
    logic [9:0]  clr_out_q;

    // Pending requests are resolved by the destination computer; clears are
    // issued unconditionally, so the raw request vectors are not consulted.
    logic unused_req;
    assign unused_req = ^{req_in, req_out};

    // Hall-call bit for the up button at floor f (exists on floors 1..5).
    function automatic logic [9:0] up_call(input logic [2:0] f);
        logic [9:0] m;
        m = '0;
        case (f)
            3'd1:    m[0] = 1'b1;
            3'd2:    m[2] = 1'b1;
            3'd3:    m[4] = 1'b1;
            3'd4:    m[6] = 1'b1;
            3'd5:    m[8] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Hall-call bit for the down button at floor f (exists on floors 2..6).
    function automatic logic [9:0] down_call(input logic [2:0] f);
        logic [9:0] m;
        m = '0;
        case (f)
            3'd2:    m[1] = 1'b1;
            3'd3:    m[3] = 1'b1;
            3'd4:    m[5] = 1'b1;
            3'd5:    m[7] = 1'b1;
            3'd6:    m[9] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // A car arriving while travelling clears the call in its direction; at the
    // terminal floors only one call button exists, so that one is cleared.
    function automatic logic [9:0] moving_call(input logic [2:0] f, input logic d);
        logic [9:0] m;
        if (d) m = (f == 3'd6) ? down_call(f) : up_call(f);
        else   m = (f == 3'd1) ? up_call(f)   : down_call(f);
        return m;
    endfunction

    // Car-button bit for floor f.
    function automatic logic [5:0] car_call(input logic [2:0] f);
        return 6'(6'd1 << (f - 3'd1));
    endfunction

    // Out-of-range floor codes are treated as "nothing to do".
    logic des_ok;
    assign des_ok = des_valid && (des != 3'd0) && (des != 3'd7);

    // Floor the car reaches at the next boundary, clamped to 1..6.
    logic [2:0] next_floor;
    logic       keep_moving;
    always_comb begin
        next_floor = now_q;
        if (dir_q && (now_q != 3'd6))
            next_floor = now_q + 3'd1;
        else if (!dir_q && (now_q != 3'd1))
            next_floor = now_q - 3'd1;
    end

    // Target still lies strictly past the floor being entered.
    assign keep_moving = des_ok && (dir_q ? (des > next_floor) : (des < next_floor));

    // Motion/door state machine with all outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            now_q     <= 3'd1;
            dir_q     <= 1'b1;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
            arrive_q  <= 1'b0;
            clr_in_q  <= '0;
            clr_out_q <= '0;
        end else begin
            // Pulses last one cycle unless re-armed below.
            arrive_q  <= 1'b0;
            clr_in_q  <= '0;
            clr_out_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (des_ok) begin
                        cnt_q <= '0;
                        if (des == now_q) begin
                            state_q   <= S_DOOR;
                            door_q    <= 1'b1;
                            arrive_q  <= 1'b1;
                            clr_in_q  <= car_call(now_q);
                            clr_out_q <= up_call(now_q) | down_call(now_q);
                        end else begin
                            state_q  <= S_MOVE;
                            dir_q    <= (des > now_q);
                            moving_q <= 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    if (cnt_q == FLOOR_LAST) begin
                        now_q <= next_floor;
                        cnt_q <= '0;
                        if (des_ok && (des == next_floor)) begin
                            state_q   <= S_DOOR;
                            moving_q  <= 1'b0;
                            door_q    <= 1'b1;
                            arrive_q  <= 1'b1;
                            clr_in_q  <= car_call(next_floor);
                            clr_out_q <= moving_call(next_floor, dir_q);
                        end else if (!keep_moving) begin
                            state_q  <= S_IDLE;
                            moving_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DOOR: begin
                    if (cnt_q == DOOR_LAST) begin
                        state_q <= S_IDLE;
                        door_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    moving_q <= 1'b0;
                    door_q   <= 1'b0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign now       = now_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign arrive    = arrive_q;
    assign clr_in    = clr_in_q;
    assign clr_out   = clr_out_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl with FLOOR_TICKS=4, DOOR_TICKS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_elevator_motion_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] des;
    logic       des_valid;
    logic [5:0] req_in;
    logic [9:0] req_out;
    logic [2:0] now;
    logic       dir;
    logic       moving;
    logic       door_open;
    logic       arrive;
    logic [5:0] clr_in;
    logic [9:0] clr_out;

    int total;
    int passed;

    elevator_motion_ctrl #(
        .FLOOR_TICKS(4),
        .DOOR_TICKS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .des      (des),
        .des_valid(des_valid),
        .req_in   (req_in),
        .req_out  (req_out),
        .now      (now),
        .dir      (dir),
        .moving   (moving),
        .door_open(door_open),
        .arrive   (arrive),
        .clr_in   (clr_in),
        .clr_out  (clr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Snapshot of the idle/reset output set.
    task automatic chk_quiet(input string tag, input logic [2:0] exp_now, input logic exp_dir);
        chk({tag, ".now"},     16'(now),       16'(exp_now));
        chk({tag, ".dir"},     16'(dir),       16'(exp_dir));
        chk({tag, ".moving"},  16'(moving),    16'd0);
        chk({tag, ".door"},    16'(door_open), 16'd0);
        chk({tag, ".arrive"},  16'(arrive),    16'd0);
        chk({tag, ".clr_in"},  16'(clr_in),    16'd0);
        chk({tag, ".clr_out"}, 16'(clr_out),   16'd0);
    endtask

    // First door cycle: arrive plus the expected clear pulses.
    task automatic chk_arrival(input string tag, input logic [2:0] exp_now,
                               input logic [5:0] exp_cin, input logic [9:0] exp_cout);
        chk({tag, ".now"},     16'(now),       16'(exp_now));
        chk({tag, ".door"},    16'(door_open), 16'd1);
        chk({tag, ".arrive"},  16'(arrive),    16'd1);
        chk({tag, ".moving"},  16'(moving),    16'd0);
        chk({tag, ".clr_in"},  16'(clr_in),    16'(exp_cin));
        chk({tag, ".clr_out"}, 16'(clr_out),   16'(exp_cout));
    endtask

    // Called on the first door cycle with des_valid already dropped.
    task automatic chk_door_close(input string tag);
        wait_neg(1);
        chk({tag, ".door2"},   16'(door_open), 16'd1);
        chk({tag, ".arrive2"}, 16'(arrive),    16'd0);
        chk({tag, ".clr2"},    16'({clr_in, clr_out}), 16'd0);
        wait_neg(1);
        chk({tag, ".door3"},   16'(door_open), 16'd1);
        wait_neg(1);
        chk({tag, ".closed"},  16'(door_open), 16'd0);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        des       = 3'd0;
        des_valid = 1'b0;
        req_in    = '0;
        req_out   = '0;

        // Reset state
        wait_neg(2);
        chk_quiet("reset", 3'd1, 1'b1);
        rst = 1'b0;

        // Floor 1 -> 3, moving service going up
        des = 3'd3; des_valid = 1'b1; req_in = 6'b000100; req_out = 10'b0000010000;
        wait_neg(1);
        chk("t1.moving", 16'(moving), 16'd1);
        chk("t1.dir",    16'(dir),    16'd1);
        chk("t1.now0",   16'(now),    16'd1);
        wait_neg(3);
        chk("t1.now_pre", 16'(now), 16'd1);
        wait_neg(1);
        chk("t1.now2",    16'(now),       16'd2);
        chk("t1.mov2",    16'(moving),    16'd1);
        chk("t1.door_no", 16'(door_open), 16'd0);
        wait_neg(4);
        chk_arrival("t1", 3'd3, 6'b000100, 10'b0000010000);
        des_valid = 1'b0; req_in = '0; req_out = '0;
        chk_door_close("t1");

        // Stopped service at floor 3: both hall calls cleared next cycle
        des = 3'd3; des_valid = 1'b1; req_out = 10'b0000001000;
        wait_neg(1);
        chk_arrival("t2", 3'd3, 6'b000100, 10'b0000011000);
        des_valid = 1'b0; req_out = '0;
        chk_door_close("t2");

        // Floor 3 -> 1 going down: terminal floor clears the up call (bit 0)
        des = 3'd1; des_valid = 1'b1;
        wait_neg(1);
        chk("t3.dir", 16'(dir), 16'd0);
        wait_neg(8);
        chk_arrival("t3", 3'd1, 6'b000001, 10'b0000000001);
        des_valid = 1'b0;
        chk_door_close("t3");

        // Invalid floor codes 7 and 0 keep the car idle
        des = 3'd7; des_valid = 1'b1;
        wait_neg(2);
        chk_quiet("des7", 3'd1, 1'b0);
        des = 3'd0;
        wait_neg(2);
        chk_quiet("des0", 3'd1, 1'b0);

        // Heading to 5, retarget to 2 mid-floor: serve floor 2 at the boundary
        des = 3'd5;
        wait_neg(1);
        chk("t4.moving", 16'(moving), 16'd1);
        des = 3'd2;
        wait_neg(4);
        chk_arrival("t4", 3'd2, 6'b000010, 10'b0000000100);
        chk("t4.dir", 16'(dir), 16'd1);
        des_valid = 1'b0;
        chk_door_close("t4");

        // Floor 2 -> 4, request withdrawn mid-travel: stop idle at floor 3
        des = 3'd4; des_valid = 1'b1;
        wait_neg(1);
        chk("t5.moving", 16'(moving), 16'd1);
        wait_neg(2);
        des_valid = 1'b0;
        wait_neg(2);
        chk_quiet("t5", 3'd3, 1'b1);
        wait_neg(1);
        chk_quiet("t5b", 3'd3, 1'b1);

        // Floor 3 -> 6 going up: terminal floor clears the down call (bit 9)
        des = 3'd6; des_valid = 1'b1;
        wait_neg(9);
        chk("t6.now5", 16'(now),    16'd5);
        chk("t6.mov5", 16'(moving), 16'd1);
        wait_neg(4);
        chk_arrival("t6", 3'd6, 6'b100000, 10'b1000000000);
        chk("t6.dir", 16'(dir), 16'd1);
        des_valid = 1'b0;
        chk_door_close("t6");

        // Floor 6 -> 3 going down: down call at floor 3 (bit 3)
        des = 3'd3; des_valid = 1'b1;
        wait_neg(13);
        chk_arrival("t7", 3'd3, 6'b000100, 10'b0000001000);
        chk("t7.dir", 16'(dir), 16'd0);
        des_valid = 1'b0;
        chk_door_close("t7");

        // Reset while between floors 3 and 4 takes effect without a clock edge
        des = 3'd5; des_valid = 1'b1;
        wait_neg(3);
        chk("t8.moving", 16'(moving), 16'd1);
        chk("t8.now",    16'(now),    16'd3);
        #2 rst = 1'b1;
        #1 chk_quiet("t8.async", 3'd1, 1'b1);
        wait_neg(1);
        rst = 1'b0; des_valid = 1'b0;
        wait_neg(1);
        chk_quiet("t8.after", 3'd1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
